data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe_if.sv | 16 +
 rtl/data_mem_pipe.sv | 72 +++++++
 tb/tb_data_mem_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/data_mem_pipe_if.sv
// data_mem_pipe_if: request/response bundle for the pipelined data memory.
interface data_mem_pipe_if #(parameter int ADDR_W = 8);
  logic              request;
  logic              we_re;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W+1:0] address;
  logic [31:0]       data_in;
  logic              valid;
  logic [31:0]       data_out;
  logic              err;
  modport master (output request, we_re, size, unsigned_ld, address, data_in,
                  input valid, data_out, err);
  modport slave (input request, we_re, size, unsigned_ld, address, data_in,
                 output valid, data_out, err);
endinterface

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: single-port 32-bit word memory with byte/half lanes, fault detection
// and a fixed LATENCY-deep result pipeline.
module data_mem_pipe #(
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 1,
  parameter int INSTR_MEM = 0
) (
  input logic            clk,
  input logic            rst,
  data_mem_pipe_if.slave bus
);
  typedef struct packed {
    logic        v;
    logic        e;
    logic [1:0]  sz;
    logic        u;
    logic [1:0]  off;
    logic [31:0] w;
  } stage_t;
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("data_mem_pipe: LATENCY must be 1..4");
  end
  logic [31:0]       mem_q [2**ADDR_W];
  stage_t            st_q [LATENCY];
  stage_t            st_d;
  stage_t            fin;
  logic [1:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              wr;
  logic [3:0]        lane;
  logic [31:0]       wdata;
  logic [31:0]       ext;
  always_comb begin
    off   = bus.address[1:0];
    idx   = bus.address[ADDR_W+1:2];
    fault = (bus.size == 2'b11) | ((bus.size == 2'b01) & off[0]) |
            ((bus.size == 2'b10) & (|off)) | (bus.we_re & (INSTR_MEM != 0));
    wr    = bus.request & bus.we_re & ~fault;
    lane  = bus.size == 2'b00 ? 4'b0001 << off : bus.size == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata = bus.size == 2'b00 ? {4{bus.data_in[7:0]}} :
            bus.size == 2'b01 ? {2{bus.data_in[15:0]}} : bus.data_in;
    st_d.v   = bus.request;
    st_d.e   = bus.request & fault;
    st_d.sz  = bus.size;
    st_d.u   = bus.unsigned_ld;
    st_d.off = off;
    // stores and faulted accesses carry a zero word so they complete with data_out=0
    st_d.w   = (bus.request & ~bus.we_re & ~fault) ? mem_q[idx] : '0;
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wr & lane[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= st_d;
      for (int i = 1; i < LATENCY; i++) st_q[i] <= st_q[i-1];
    end
  end
  always_comb begin
    fin = st_q[LATENCY-1];
    ext = fin.sz == 2'b00 ? {{24{~fin.u & fin.w[8*fin.off+7]}}, fin.w[8*fin.off +: 8]} :
          fin.sz == 2'b01 ? {{16{~fin.u & fin.w[16*fin.off[1]+15]}}, fin.w[16*fin.off[1] +: 16]} :
          fin.w;
  end
  assign bus.valid    = fin.v;
  assign bus.err      = fin.v & fin.e;
  assign bus.data_out = fin.v ? ext : '0;
endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: directed checks of LATENCY=1, LATENCY=3 and read-only instances
// driven by one shared stimulus stream.
module tb_data_mem_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        u;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] x;
    logic        e;
  } vec_t;
  vec_t q[$];
  data_mem_pipe_if #(.ADDR_W(8)) b1 ();
  data_mem_pipe_if #(.ADDR_W(8)) b3 ();
  data_mem_pipe_if #(.ADDR_W(8)) bi ();
  assign b1.request = req;  assign b3.request = req;  assign bi.request = req;
  assign b1.we_re = we;     assign b3.we_re = we;     assign bi.we_re = we;
  assign b1.size = sz;      assign b3.size = sz;      assign bi.size = sz;
  assign b1.unsigned_ld = uns; assign b3.unsigned_ld = uns; assign bi.unsigned_ld = uns;
  assign b1.address = addr; assign b3.address = addr; assign bi.address = addr;
  assign b1.data_in = din;  assign b3.data_in = din;  assign bi.data_in = din;
  data_mem_pipe #(.ADDR_W(8), .LATENCY(1), .INSTR_MEM(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_pipe #(.ADDR_W(8), .LATENCY(3), .INSTR_MEM(0)) u3 (.clk(clk), .rst(rst), .bus(b3));
  data_mem_pipe #(.ADDR_W(8), .LATENCY(1), .INSTR_MEM(1)) ui (.clk(clk), .rst(rst), .bus(bi));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void add(input logic w, input logic [1:0] s, input logic u,
                              input logic [9:0] a, input logic [31:0] d,
                              input logic [31:0] x, input logic e);
    q.push_back('{w, s, u, a, d, x, e});
  endfunction
  task automatic idle_check(input string tag);
    chk({tag, " u1.valid"}, {31'd0, b1.valid}, 0);
    chk({tag, " u1.err"}, {31'd0, b1.err}, 0);
    chk({tag, " u1.data"}, b1.data_out, 0);
    chk({tag, " u3.valid"}, {31'd0, b3.valid}, 0);
    chk({tag, " u3.err"}, {31'd0, b3.err}, 0);
    chk({tag, " u3.data"}, b3.data_out, 0);
  endtask
  // Issues the queued vectors back to back and checks every output cycle of each instance.
  task automatic run(input string tag);
    int nt = q.size();
    for (int n = 0; n <= nt + 3; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= nt) begin
        vec_t v = q[n-1];
        chk({tag, " u1.valid"}, {31'd0, b1.valid}, 1);
        chk({tag, " u1.err"}, {31'd0, b1.err}, {31'd0, v.e});
        chk({tag, " u1.data"}, b1.data_out, v.x);
        chk({tag, " ui.valid"}, {31'd0, bi.valid}, 1);
        chk({tag, " ui.err"}, {31'd0, bi.err}, {31'd0, v.e | v.we});
        if (v.e | v.we) chk({tag, " ui.data"}, bi.data_out, 0);
      end else begin
        chk({tag, " u1.idle"}, {31'd0, b1.valid}, 0);
        chk({tag, " u1.idle_data"}, b1.data_out, 0);
      end
      if (n >= 3 && n <= nt + 2) begin
        vec_t v = q[n-3];
        chk({tag, " u3.valid"}, {31'd0, b3.valid}, 1);
        chk({tag, " u3.err"}, {31'd0, b3.err}, {31'd0, v.e});
        chk({tag, " u3.data"}, b3.data_out, v.x);
      end else begin
        chk({tag, " u3.idle"}, {31'd0, b3.valid}, 0);
        chk({tag, " u3.idle_err"}, {31'd0, b3.err}, 0);
      end
      if (n < nt) begin
        req = 1'b1; we = q[n].we; sz = q[n].sz; uns = q[n].u; addr = q[n].a; din = q[n].d;
      end else begin
        req = 1'b0; we = 1'b0; din = '0;
      end
    end
    q.delete();
  endtask
  initial begin
    #1 idle_check("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    add(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0);
    run("sw_10");
    add(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0);
    run("lw_10");
    add(1, 2'b10, 0, 10'h020, 32'h80F07F81, 32'h0, 0);
    run("sw_20");
    add(0, 2'b00, 0, 10'h020, 32'h0, 32'hFFFFFF81, 0);
    run("lb_20");
    add(0, 2'b00, 1, 10'h023, 32'h0, 32'h00000080, 0);
    run("lbu_23");
    add(0, 2'b01, 0, 10'h022, 32'h0, 32'hFFFF80F0, 0);
    run("lh_22");
    add(0, 2'b01, 1, 10'h020, 32'h0, 32'h00007F81, 0);
    run("lhu_20");
    add(1, 2'b10, 0, 10'h030, 32'h11223344, 32'h0, 0);
    add(1, 2'b00, 0, 10'h031, 32'h000000AA, 32'h0, 0);
    add(1, 2'b01, 0, 10'h032, 32'h0000BEEF, 32'h0, 0);
    add(0, 2'b10, 0, 10'h030, 32'h0, 32'hBEEFAA44, 0);
    run("masked");
    add(0, 2'b10, 0, 10'h002, 32'h0, 32'h0, 1);
    add(0, 2'b01, 0, 10'h001, 32'h0, 32'h0, 1);
    add(0, 2'b11, 0, 10'h010, 32'h0, 32'h0, 1);
    add(1, 2'b10, 0, 10'h012, 32'h12345678, 32'h0, 1);
    add(1, 2'b01, 0, 10'h011, 32'h00005555, 32'h0, 1);
    add(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0);
    run("fault");
    add(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0);
    add(0, 2'b10, 0, 10'h020, 32'h0, 32'h80F07F81, 0);
    add(0, 2'b10, 0, 10'h030, 32'h0, 32'hBEEFAA44, 0);
    add(0, 2'b00, 1, 10'h021, 32'h0, 32'h0000007F, 0);
    run("b2b");
    add(1, 2'b10, 0, 10'h040, 32'hCAFEF00D, 32'h0, 0);
    add(0, 2'b10, 0, 10'h040, 32'h0, 32'hCAFEF00D, 0);
    add(1, 2'b01, 0, 10'h042, 32'h00001234, 32'h0, 0);
    add(0, 2'b01, 1, 10'h042, 32'h0, 32'h00001234, 0);
    add(1, 2'b00, 0, 10'h043, 32'h00000055, 32'h0, 0);
    add(0, 2'b10, 0, 10'h040, 32'h0, 32'h5534F00D, 0);
    run("raw");
    @(negedge clk);
    req = 1'b1; we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 10'h010;
    @(negedge clk);
    addr = 10'h020;
    @(negedge clk);
    req = 1'b0;
    chk("inflight u1.valid", {31'd0, b1.valid}, 1);
    #1 rst = 1'b0;
    #1 idle_check("async_rst");
    @(negedge clk);
    idle_check("rst_hold");
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_check("post_rst");
    end
    add(0, 2'b10, 0, 10'h040, 32'h0, 32'h5534F00D, 0);
    add(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0);
    run("persist");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
